// File: rtl/alu_issue_if.sv
// Handshake and bus bundle between the ALU issue sequencer, its upstream driver,
// the ALU itself and the downstream result consumer.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] in_ahigh;
  logic [3:0]  in_mode;
  logic [2:0]  in_flag;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_ahigh;
  logic [3:0]  alu_mode;
  logic [2:0]  alu_flag;
  logic [63:0] alu_out;
  logic [4:0]  alu_flag_out;

  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic [4:0]  res_flags;
  logic [3:0]  res_mode;

  modport slave (
    input  in_valid, in_a, in_b, in_ahigh, in_mode, in_flag,
    output in_ready,
    output alu_a, alu_b, alu_ahigh, alu_mode, alu_flag,
    input  alu_out, alu_flag_out,
    output res_valid, res_data, res_flags, res_mode,
    input  res_ready
  );

  modport master (
    output in_valid, in_a, in_b, in_ahigh, in_mode, in_flag,
    input  in_ready,
    input  alu_a, alu_b, alu_ahigh, alu_mode, alu_flag,
    output alu_out, alu_flag_out,
    input  res_valid, res_data, res_flags, res_mode,
    output res_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU front-end sequencer: registers one operation onto the ALU, waits a
// mode-dependent settle time, captures the result and hands it downstream.
//
// state  | meaning
// IDLE   | ready for a new operation
// WAIT   | operands held on ALU, counting down settle latency
// DONE   | result captured, waiting for downstream to take it
module alu_issue_ctrl #(
  parameter int LAT_INT = 1,
  parameter int LAT_MUL = 4,
  parameter int LAT_FLT = 6,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus,
  output logic [15:0] op_count,
  output logic        busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d, ahigh_q, ahigh_d;
  logic [3:0]       mode_q, mode_d;
  logic [2:0]       flag_q, flag_d;
  logic [63:0]      res_data_q, res_data_d;
  logic [4:0]       res_flags_q, res_flags_d;
  logic [3:0]       res_mode_q, res_mode_d;
  logic             res_valid_q, res_valid_d;
  logic [15:0]      op_count_q, op_count_d;
  logic [CNT_W-1:0] lat_sel;

  always_comb begin
    lat_sel = CNT_W'(LAT_INT);
    if (bus.in_mode == 4'hA)
      lat_sel = CNT_W'(LAT_MUL);
    else if (bus.in_mode >= 4'hC)
      lat_sel = CNT_W'(LAT_FLT);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    ahigh_d     = ahigh_q;
    mode_d      = mode_q;
    flag_d      = flag_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_mode_d  = res_mode_q;
    res_valid_d = res_valid_q;
    op_count_d  = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          ahigh_d = bus.in_ahigh;
          mode_d  = bus.in_mode;
          flag_d  = bus.in_flag;
          cnt_d   = lat_sel;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_ONE) begin
          res_data_d  = bus.alu_out;
          res_mode_d  = mode_q;
          // Only add/sub produce meaningful flags; everything else reports zero.
          res_flags_d = (mode_q == 4'h8 || mode_q == 4'h9) ? bus.alu_flag_out : 5'd0;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          op_count_d  = op_count_q + 16'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ahigh_q     <= '0;
      mode_q      <= '0;
      flag_q      <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_mode_q  <= '0;
      res_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ahigh_q     <= ahigh_d;
      mode_q      <= mode_d;
      flag_q      <= flag_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_mode_q  <= res_mode_d;
      res_valid_q <= res_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_ahigh = ahigh_q;
  assign bus.alu_mode  = mode_q;
  assign bus.alu_flag  = flag_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_flags = res_flags_q;
  assign bus.res_mode  = res_mode_q;
  assign op_count      = op_count_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; the bench plays both the upstream driver
// and the ALU, presenting the true result only in the cycle before capture.
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_issue_if bus();
  logic [15:0] op_count;
  logic        busy;

  alu_issue_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .op_count (op_count),
    .busy     (busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic accept(input logic [3:0] mode, input logic [2:0] flag,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] ah);
    bus.in_mode  = mode;
    bus.in_flag  = flag;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_ahigh = ah;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("acc_in_ready", bus.in_ready, 0);
    check("acc_busy", busy, 1);
    check("acc_alu_a", bus.alu_a, a);
    check("acc_alu_b", bus.alu_b, b);
    check("acc_alu_mode", bus.alu_mode, mode);
  endtask

  // Walk through the settle window; any early capture sees the inverted value.
  task automatic settle(input int lat, input logic [63:0] out, input logic [4:0] fo);
    for (int k = 1; k <= lat; k++) begin
      check("early_valid", bus.res_valid, 0);
      if (k == lat) begin
        bus.alu_out      = out;
        bus.alu_flag_out = fo;
      end else begin
        bus.alu_out      = ~out;
        bus.alu_flag_out = ~fo;
      end
      tick();
    end
    bus.alu_out      = 64'hDEAD_BEEF_0BAD_F00D;
    bus.alu_flag_out = 5'b01011;
    check("cap_valid", bus.res_valid, 1);
  endtask

  task automatic check_res(input logic [63:0] data, input logic [4:0] flags, input logic [3:0] mode);
    check("res_data", bus.res_data, data);
    check("res_flags", bus.res_flags, flags);
    check("res_mode", bus.res_mode, mode);
  endtask

  task automatic take_res(input logic [15:0] exp_count);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("rel_valid", bus.res_valid, 0);
    check("rel_in_ready", bus.in_ready, 1);
    check("rel_op_count", op_count, exp_count);
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_a         = '0;
    bus.in_b         = '0;
    bus.in_ahigh     = '0;
    bus.in_mode      = '0;
    bus.in_flag      = '0;
    bus.alu_out      = '0;
    bus.alu_flag_out = '0;
    bus.res_ready    = 1'b0;

    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_op_count", op_count, 0);
    rst = 1'b1;
    tick();
    check("idle_hold", bus.in_ready, 1);

    // Add 5+3
    accept(4'h8, 3'd0, 32'd5, 32'd3, 32'd0);
    settle(1, 64'h8, 5'b00000);
    check_res(64'h8, 5'b00000, 4'h8);
    take_res(16'd1);

    // Sub 3-5: CF and SF set
    accept(4'h9, 3'd0, 32'd3, 32'd5, 32'd0);
    settle(1, 64'h0000_0000_FFFF_FFFE, 5'b10100);
    check_res(64'h0000_0000_FFFF_FFFE, 5'b10100, 4'h9);
    take_res(16'd2);

    // Mul 7*6, flags must be masked
    accept(4'hA, 3'd0, 32'd7, 32'd6, 32'd0);
    settle(4, 64'h2A, 5'b11111);
    check_res(64'h2A, 5'b00000, 4'hA);
    take_res(16'd3);

    // AND with backpressure and a pending second request
    accept(4'h2, 3'd0, 32'hF0, 32'h3C, 32'd0);
    settle(1, 64'h30, 5'b00010);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h11;
    bus.in_b     = 32'h22;
    bus.in_mode  = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_res_data", bus.res_data, 64'h30);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_valid", bus.res_valid, 1);
      check("bp_alu_a", bus.alu_a, 32'hF0);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("bp_rel_ready", bus.in_ready, 1);
    check("bp_rel_count", op_count, 16'd4);
    check("bp_no_early_acc", bus.alu_a, 32'hF0);
    tick();
    bus.in_valid = 1'b0;
    check("bp_acc2_a", bus.alu_a, 32'h11);
    check("bp_acc2_ready", bus.in_ready, 0);
    settle(1, 64'h33, 5'b00001);
    check_res(64'h33, 5'b00000, 4'h0);
    take_res(16'd5);

    // Reset during a float op's WAIT
    accept(4'hC, 3'd1, 32'd1, 32'd2, 32'd3);
    bus.alu_out = 64'h1234;
    tick();
    check("mid_busy", busy, 1);
    rst = 1'b0;
    tick();
    check("mr_in_ready", bus.in_ready, 1);
    check("mr_busy", busy, 0);
    check("mr_res_valid", bus.res_valid, 0);
    check("mr_res_data", bus.res_data, 0);
    check("mr_res_mode", bus.res_mode, 0);
    check("mr_res_flags", bus.res_flags, 0);
    check("mr_alu_a", bus.alu_a, 0);
    check("mr_alu_ahigh", bus.alu_ahigh, 0);
    check("mr_alu_mode", bus.alu_mode, 0);
    check("mr_op_count", op_count, 0);
    rst = 1'b1;
    tick();
    check("mr_idle", bus.res_valid, 0);

    // Float latency
    accept(4'hF, 3'd0, 32'h3F80_0000, 32'h4000_0000, 32'd0);
    settle(6, 64'h4040_0000, 5'b00100);
    check_res(64'h4040_0000, 5'b00000, 4'hF);
    take_res(16'd1);

    // Completion counter wrap
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    check("wrap_pre", op_count, 16'hFFFF);
    accept(4'h3, 3'd0, 32'h1, 32'h2, 32'd0);
    settle(1, 64'h3, 5'b00000);
    check_res(64'h3, 5'b00000, 4'h3);
    take_res(16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
